// File: rtl/cute_lock_sched_gate.sv
// rtl/cute_lock_sched_gate.sv - time-scheduled key-gating stage with sticky lockout and mismatch counter
module cute_lock_sched_gate #(
   parameter int                          KEY_WIDTH  = 3,
   parameter int                          NUM_KEYS   = 4,
   parameter int                          DATA_WIDTH = 1,
   parameter logic [NUM_KEYS*KEY_WIDTH-1:0] KEY_TABLE = '0,
   parameter bit                          STICKY     = 1'b0,
   parameter int                          ERR_W      = 8,
   localparam int                         SLOT_W     = ($clog2(NUM_KEYS) < 1) ? 1 : $clog2(NUM_KEYS)
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [KEY_WIDTH-1:0]  keyinput,
   input  logic                  step_en,
   input  logic [DATA_WIDTH-1:0] true_in,
   input  logic [DATA_WIDTH-1:0] decoy_in,
   output logic [DATA_WIDTH-1:0] locked_out,
   output logic [SLOT_W-1:0]     slot,
   output logic                  key_ok,
   output logic                  lockout,
   output logic [ERR_W-1:0]      err_cnt
);

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_KEYS - 1);

   logic [SLOT_W-1:0]     r_slot;
   logic [DATA_WIDTH-1:0] r_locked_out;
   logic                  r_key_ok;
   logic                  r_lockout;
   logic [ERR_W-1:0]      r_err_cnt;

   logic [KEY_WIDTH-1:0]  w_exp_key;
   logic                  w_match;
   logic                  w_pass;
   logic                  w_err_sat;

   // Look up the expected key for the current (pre-increment) slot
   always_comb begin
      w_exp_key = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (r_slot == SLOT_W'(i)) begin
            w_exp_key = KEY_TABLE[i*KEY_WIDTH +: KEY_WIDTH];
         end
      end
   end

   assign w_match   = (keyinput == w_exp_key);
   assign w_pass    = w_match & ~r_lockout;
   assign w_err_sat = &r_err_cnt;

   // Slot counter: advances on step_en and wraps at the last slot for any depth
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_slot <= '0;
      end else if (step_en) begin
         r_slot <= (r_slot == LAST_SLOT) ? '0 : r_slot + SLOT_W'(1);
      end
   end

   // Gated data and match flag: true values only on an effective pass
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_locked_out <= '0;
         r_key_ok     <= 1'b0;
      end else begin
         r_locked_out <= w_pass ? true_in : decoy_in;
         r_key_ok     <= w_pass;
      end
   end

   // Lockout latches on the first real mismatch when sticky mode is built in
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_lockout <= 1'b0;
      end else if (STICKY && !w_match) begin
         r_lockout <= 1'b1;
      end
   end

   // Saturating count of cycles whose key did not match the schedule
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_err_cnt <= '0;
      end else if (!w_match && !w_err_sat) begin
         r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
   end

   assign locked_out = r_locked_out;
   assign slot       = r_slot;
   assign key_ok     = r_key_ok;
   assign lockout    = r_lockout;
   assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_cute_lock_sched_gate.sv
// tb/tb_cute_lock_sched_gate.sv - directed self-checking bench for cute_lock_sched_gate
module tb_cute_lock_sched_gate;

   logic       clock;
   logic       reset_n;
   logic [2:0] keyinput;
   logic       step_en;
   logic [1:0] true_in;
   logic [1:0] decoy_in;

   // DUT A: non-sticky, depth 4
   logic [1:0] a_locked_out;
   logic [1:0] a_slot;
   logic       a_key_ok;
   logic       a_lockout;
   logic [7:0] a_err_cnt;
   // DUT B: sticky, depth 4
   logic [1:0] b_locked_out;
   logic [1:0] b_slot;
   logic       b_key_ok;
   logic       b_lockout;
   logic [7:0] b_err_cnt;
   // DUT C: depth 3
   logic [1:0] c_locked_out;
   logic [1:0] c_slot;
   logic       c_key_ok;
   logic       c_lockout;
   logic [7:0] c_err_cnt;
   // DUT D: 2-bit error counter
   logic [1:0] d_locked_out;
   logic [1:0] d_slot;
   logic       d_key_ok;
   logic       d_lockout;
   logic [1:0] d_err_cnt;

   int errors = 0;
   int checks = 0;

   cute_lock_sched_gate #(.KEY_WIDTH(3), .NUM_KEYS(4), .DATA_WIDTH(2), .KEY_TABLE(12'h3D5),
                          .STICKY(1'b0), .ERR_W(8)) u_a (
      .clock(clock), .reset_n(reset_n), .keyinput(keyinput), .step_en(step_en),
      .true_in(true_in), .decoy_in(decoy_in), .locked_out(a_locked_out), .slot(a_slot),
      .key_ok(a_key_ok), .lockout(a_lockout), .err_cnt(a_err_cnt));

   cute_lock_sched_gate #(.KEY_WIDTH(3), .NUM_KEYS(4), .DATA_WIDTH(2), .KEY_TABLE(12'h3D5),
                          .STICKY(1'b1), .ERR_W(8)) u_b (
      .clock(clock), .reset_n(reset_n), .keyinput(keyinput), .step_en(step_en),
      .true_in(true_in), .decoy_in(decoy_in), .locked_out(b_locked_out), .slot(b_slot),
      .key_ok(b_key_ok), .lockout(b_lockout), .err_cnt(b_err_cnt));

   cute_lock_sched_gate #(.KEY_WIDTH(3), .NUM_KEYS(3), .DATA_WIDTH(2), .KEY_TABLE(9'o165),
                          .STICKY(1'b0), .ERR_W(8)) u_c (
      .clock(clock), .reset_n(reset_n), .keyinput(keyinput), .step_en(step_en),
      .true_in(true_in), .decoy_in(decoy_in), .locked_out(c_locked_out), .slot(c_slot),
      .key_ok(c_key_ok), .lockout(c_lockout), .err_cnt(c_err_cnt));

   cute_lock_sched_gate #(.KEY_WIDTH(3), .NUM_KEYS(4), .DATA_WIDTH(2), .KEY_TABLE(12'h3D5),
                          .STICKY(1'b0), .ERR_W(2)) u_d (
      .clock(clock), .reset_n(reset_n), .keyinput(keyinput), .step_en(step_en),
      .true_in(true_in), .decoy_in(decoy_in), .locked_out(d_locked_out), .slot(d_slot),
      .key_ok(d_key_ok), .lockout(d_lockout), .err_cnt(d_err_cnt));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset_n = 1'b0;
      for (int i = 0; i < n; i++) tick();
      reset_n = 1'b1;
   endtask

   initial begin
      int keys1 [5] = '{5, 2, 7, 1, 5};
      int keys2 [4] = '{5, 2, 3, 1};
      int keys3 [5] = '{5, 4, 7, 1, 5};
      int slots4 [4] = '{0, 1, 2, 0};
      int keys4 [4] = '{5, 6, 1, 5};
      int sat5 [6] = '{1, 2, 3, 3, 3, 3};

      reset_n  = 1'b0;
      keyinput = 3'd0;
      step_en  = 1'b1;
      true_in  = 2'b10;
      decoy_in = 2'b01;

      // Scenario 1: reset, then the correct schedule
      tick();
      tick();
      check("s1_rst_locked", a_locked_out, 2'b00);
      check("s1_rst_slot", a_slot, 0);
      check("s1_rst_key_ok", a_key_ok, 0);
      check("s1_rst_lockout", a_lockout, 0);
      check("s1_rst_err", a_err_cnt, 0);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("s1_pre_slot", a_slot, i % 4);
         keyinput = 3'(keys1[i]);
         tick();
         check("s1_key_ok", a_key_ok, 1);
         check("s1_locked", a_locked_out, 2'b10);
         check("s1_err", a_err_cnt, 0);
      end

      // Scenario 2: wrong key at slot 2, non-sticky
      do_reset(1);
      for (int i = 0; i < 4; i++) begin
         keyinput = 3'(keys2[i]);
         tick();
         if (i == 2) begin
            check("s2_bad_locked", a_locked_out, 2'b01);
            check("s2_bad_key_ok", a_key_ok, 0);
            check("s2_bad_err", a_err_cnt, 1);
         end
      end
      check("s2_next_locked", a_locked_out, 2'b10);
      check("s2_next_key_ok", a_key_ok, 1);
      check("s2_next_lockout", a_lockout, 0);
      check("s2_next_err", a_err_cnt, 1);

      // Scenario 3: sticky lockout on DUT B
      do_reset(1);
      for (int i = 0; i < 5; i++) begin
         keyinput = 3'(keys3[i]);
         tick();
         if (i == 0) begin
            check("s3_first_ok", b_key_ok, 1);
            check("s3_first_lockout", b_lockout, 0);
         end else begin
            check("s3_locked", b_locked_out, 2'b01);
            check("s3_key_ok", b_key_ok, 0);
            check("s3_lockout", b_lockout, 1);
            check("s3_err", b_err_cnt, 1);
         end
      end
      reset_n = 1'b0;
      tick();
      check("s3_rst_locked", b_locked_out, 0);
      check("s3_rst_slot", b_slot, 0);
      check("s3_rst_key_ok", b_key_ok, 0);
      check("s3_rst_lockout", b_lockout, 0);
      check("s3_rst_err", b_err_cnt, 0);
      reset_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         keyinput = 3'(keys1[i]);
         tick();
         check("s3_resume_ok", b_key_ok, 1);
         check("s3_resume_locked", b_locked_out, 2'b10);
      end
      check("s3_resume_slot", b_slot, 2);

      // Scenario 4: step hold and depth-3 wrap on DUT C
      do_reset(1);
      step_en  = 1'b0;
      keyinput = 3'd5;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("s4_hold_slot", c_slot, 0);
         check("s4_hold_ok", c_key_ok, 1);
      end
      step_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("s4_pre_slot", c_slot, slots4[i]);
         keyinput = 3'(keys4[i]);
         tick();
         check("s4_step_ok", c_key_ok, 1);
      end
      check("s4_err", c_err_cnt, 0);

      // Scenario 5: error counter saturation on DUT D
      do_reset(1);
      keyinput = 3'd0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("s5_err", d_err_cnt, sat5[i]);
         check("s5_key_ok", d_key_ok, 0);
      end

      // Scenario 6: reset mid-schedule on DUT A
      do_reset(1);
      for (int i = 0; i < 2; i++) begin
         keyinput = 3'(keys1[i]);
         tick();
      end
      check("s6_mid_slot", a_slot, 2);
      check("s6_mid_lockout", a_lockout, 0);
      keyinput = 3'd3;
      reset_n  = 1'b0;
      tick();
      check("s6_rst_slot", a_slot, 0);
      check("s6_rst_err", a_err_cnt, 0);
      check("s6_rst_locked", a_locked_out, 0);
      check("s6_rst_key_ok", a_key_ok, 0);
      reset_n  = 1'b1;
      keyinput = 3'd5;
      tick();
      check("s6_post_ok", a_key_ok, 1);
      check("s6_post_locked", a_locked_out, 2'b10);
      check("s6_post_slot", a_slot, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
